param_sync_fifo: RTL and testbench

Parametrised single-clock synchronous FIFO: next generation of the 8-bit × 1024 read/write-mode FIFO. It replaces the shared `re_wr` mode select with independent write and read enables, so one cycle can carry both a write and a read. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, and optional sticky error flags. It sits between a producer and a consumer in the same clock domain as a general-purpose rate-smoothing buffer.

---
 rtl/param_sync_fifo.sv | 119 +++++++++++
 tb/tb_param_sync_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with independent read/write enables, occupancy count and
// threshold flags. Define FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow error flags.
module param_sync_fifo #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned AF_THRESH = DEPTH - 4,
   parameter int unsigned AE_THRESH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         data_out,
   output logic                     data_valid,
   output logic                     full_flag,
   output logic                     empty_flag,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wp_q, wp_d;
   logic [AW-1:0]    rp_q, rp_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             wa, ra;

   // Flags come from the registered count only, so no enable-to-flag combinational path exists.
   assign full_flag    = (count_q == CW'(DEPTH));
   assign empty_flag   = (count_q == '0);
   assign almost_full  = (32'(count_q) >= AF_THRESH);
   assign almost_empty = (32'(count_q) <= AE_THRESH);

   assign count      = count_q;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;

   always_comb begin
      wa           = wr_en & ~full_flag;
      ra           = rd_en & ~empty_flag;
      wp_d         = wp_q;
      rp_d         = rp_q;
      count_d      = count_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;

      if (wa) begin
         wp_d = wp_q + 1'b1;
      end
      if (ra) begin
         rp_d         = rp_q + 1'b1;
         data_out_d   = mem[rp_q];
         data_valid_d = 1'b1;
      end

      unique case ({wa, ra})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q         <= '0;
         rp_q         <= '0;
         count_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
      end else begin
         wp_q         <= wp_d;
         rp_q         <= rp_d;
         count_q      <= count_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
      end
   end

   // Storage is never cleared; only writes during reset are suppressed.
   always_ff @(posedge clk) begin
      if (wa && !rst) begin
         mem[wp_q] <= data;
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_en && full_flag) begin
            overflow_q <= 1'b1;
         end
         if (rd_en && empty_flag) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised self-checking bench for param_sync_fifo against a queue-based reference model.
module tb_param_sync_fifo;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AF    = 12;
   localparam int unsigned AE    = 4;
`ifdef FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wr_en = 1'b0;
   logic             rd_en = 1'b0;
   logic [WIDTH-1:0] data = '0;
   logic [WIDTH-1:0] data_out;
   logic             data_valid, full_flag, empty_flag, almost_full, almost_empty;
   logic [4:0]       count;
   logic             overflow, underflow;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [7:0] q[$];
   logic [7:0] m_dout = '0;
   bit         m_dv = 1'b0;
   bit         m_ovf = 1'b0;
   bit         m_unf = 1'b0;

   param_sync_fifo #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .data(data), .rd_en(rd_en),
      .data_out(data_out), .data_valid(data_valid), .full_flag(full_flag),
      .empty_flag(empty_flag), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Drive one cycle, advance the model across the edge, settle 1 time unit after the edge.
   task automatic cycle(input bit wr, input logic [7:0] d, input bit rd);
      int  n;
      bit  was_full, was_empty;
      wr_en = wr;
      data  = d;
      rd_en = rd;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_dout = '0;
         m_dv   = 1'b0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else begin
         n         = q.size();
         was_full  = (n == DEPTH);
         was_empty = (n == 0);
         if (wr && was_full) m_ovf = 1'b1;
         if (rd && was_empty) m_unf = 1'b1;
         m_dv = 1'b0;
         if (rd && !was_empty) begin
            m_dout = q.pop_front();
            m_dv   = 1'b1;
         end
         if (wr && !was_full) q.push_back(d);
      end
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle(1'b1, 8'($urandom), 1'b1);
      cycle(1'b1, 8'($urandom), 1'b1);
      rst = 1'b0;
      cycle(1'b0, 8'h00, 1'b0);
      checks += 8;
      if (empty_flag !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty_flag); end
      if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got=%0b exp=1", almost_empty); end
      if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      if (full_flag !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full_flag); end
      if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%0b exp=0", almost_full); end
      if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got=%0b exp=0", data_valid); end
      if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%0h exp=0", data_out); end
      if ({overflow, underflow} !== 2'b00) begin
         errors++; $display("FAIL reset_err got=%0b%0b exp=00", overflow, underflow);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 8'(i), 1'b0);
         checks += 3;
         if (count !== 5'(i)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", count, i); end
         if (almost_full !== (i >= 12)) begin
            errors++; $display("FAIL fill_af at=%0d got=%0b exp=%0b", i, almost_full, i >= 12);
         end
         if (full_flag !== (i == 16)) begin
            errors++; $display("FAIL fill_full at=%0d got=%0b exp=%0b", i, full_flag, i == 16);
         end
      end
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b0, 8'h00, 1'b1);
         checks += 3;
         if (data_valid !== 1'b1) begin errors++; $display("FAIL drain_dv got=%0b exp=1", data_valid); end
         if (data_out !== 8'(i)) begin errors++; $display("FAIL drain_data got=%0d exp=%0d", data_out, i); end
         if (almost_empty !== (16 - i <= 4)) begin
            errors++; $display("FAIL drain_ae got=%0b exp=%0b", almost_empty, 16 - i <= 4);
         end
      end
      checks++;
      if (empty_flag !== 1'b1) begin errors++; $display("FAIL drain_empty got=%0b exp=1", empty_flag); end
   endtask

   task automatic test_overflow();
      rst = 1'b1; cycle(1'b0, 8'h00, 1'b0); rst = 1'b0;
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom_range(0, 98)), 1'b0);
      cycle(1'b1, 8'd99, 1'b0);
      checks += 2;
      if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
      if (overflow !== ERR_EN) begin errors++; $display("FAIL ovf_flag got=%0b exp=%0b", overflow, ERR_EN); end
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 8'h00, 1'b1);
         checks += 3;
         if (data_out !== m_dout) begin errors++; $display("FAIL ovf_data got=%0d exp=%0d", data_out, m_dout); end
         if (data_out === 8'd99) begin errors++; $display("FAIL ovf_leak got=99 exp=not 99"); end
         if (overflow !== ERR_EN) begin errors++; $display("FAIL ovf_sticky got=%0b exp=%0b", overflow, ERR_EN); end
      end
   endtask

   task automatic test_underflow();
      rst = 1'b1; cycle(1'b0, 8'h00, 1'b0); rst = 1'b0;
      cycle(1'b0, 8'h00, 1'b1);
      checks += 4;
      if (data_valid !== 1'b0) begin errors++; $display("FAIL unf_dv got=%0b exp=0", data_valid); end
      if (count !== 5'd0) begin errors++; $display("FAIL unf_count got=%0d exp=0", count); end
      if (underflow !== ERR_EN) begin errors++; $display("FAIL unf_flag got=%0b exp=%0b", underflow, ERR_EN); end
      cycle(1'b0, 8'h00, 1'b0);
      if (underflow !== ERR_EN) begin errors++; $display("FAIL unf_sticky got=%0b exp=%0b", underflow, ERR_EN); end
   endtask

   task automatic test_back_to_back(input int preload, input int cycles);
      rst = 1'b1; cycle(1'b0, 8'h00, 1'b0); rst = 1'b0;
      for (int i = 0; i < preload; i++) cycle(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < cycles; i++) begin
         cycle(1'b1, 8'($urandom), 1'b1);
         checks += 3;
         if (count !== 5'(q.size())) begin
            errors++; $display("FAIL b2b%0d_count got=%0d exp=%0d", preload, count, q.size());
         end
         if (data_valid !== m_dv) begin
            errors++; $display("FAIL b2b%0d_dv got=%0b exp=%0b", preload, data_valid, m_dv);
         end
         if (data_out !== m_dout) begin
            errors++; $display("FAIL b2b%0d_data got=%0h exp=%0h", preload, data_out, m_dout);
         end
      end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; cycle(1'b0, 8'h00, 1'b0); rst = 1'b0;
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0);
      rst = 1'b1;
      cycle(1'b1, 8'hA5, 1'b1);
      rst = 1'b0;
      checks += 4;
      if (count !== 5'd0) begin errors++; $display("FAIL rmid_count got=%0d exp=0", count); end
      if (empty_flag !== 1'b1) begin errors++; $display("FAIL rmid_empty got=%0b exp=1", empty_flag); end
      if (data_valid !== 1'b0 || data_out !== 8'h00) begin
         errors++; $display("FAIL rmid_out got=%0b/%0h exp=0/00", data_valid, data_out);
      end
      if (almost_empty !== 1'b1 || almost_full !== 1'b0 || full_flag !== 1'b0) begin
         errors++; $display("FAIL rmid_flags got=%0b%0b%0b exp=100", almost_empty, almost_full, full_flag);
      end
      cycle(1'b1, 8'h5A, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      checks += 2;
      if (data_valid !== 1'b1) begin errors++; $display("FAIL rmid_rd_dv got=%0b exp=1", data_valid); end
      if (data_out !== 8'h5A) begin errors++; $display("FAIL rmid_rd_data got=%0h exp=5a", data_out); end
   endtask

   task automatic test_random();
      bit w, r;
      rst = 1'b1; cycle(1'b0, 8'h00, 1'b0); rst = 1'b0;
      for (int i = 0; i < 400; i++) begin
         w = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 30));
         r = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
         cycle(w, 8'($urandom), r);
         checks++;
         if (count !== 5'(q.size()) || full_flag !== (q.size() == DEPTH) ||
             empty_flag !== (q.size() == 0) || almost_full !== (q.size() >= AF) ||
             almost_empty !== (q.size() <= AE) || data_valid !== m_dv || data_out !== m_dout ||
             overflow !== (ERR_EN & m_ovf) || underflow !== (ERR_EN & m_unf)) begin
            errors++;
            $display("FAIL rand_cyc%0d got cnt=%0d f=%0b e=%0b af=%0b ae=%0b dv=%0b d=%0h o=%0b u=%0b exp cnt=%0d dv=%0b d=%0h o=%0b u=%0b",
                     i, count, full_flag, empty_flag, almost_full, almost_empty, data_valid,
                     data_out, overflow, underflow, q.size(), m_dv, m_dout, ERR_EN & m_ovf,
                     ERR_EN & m_unf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_back_to_back(8, 40);
      test_back_to_back(16, 20);
      test_back_to_back(0, 20);
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
